regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and sequencer for the 16x16 register file.
- Shares the register file's single general write port (write_reg/write_data, reg_write[1]) among NREQ single-result requesters, e.g. ALU, load unit and move/immediate.
- Also serves one multiply/divide requester that needs both ports in the same cycle: low word to Rd, high word to R0 (reg_write[0]).
- Registered outputs drive the register file write inputs directly.

Parameters:
- NREQ, 3, number of general (single-write) requesters
- DW, 16, data width
- AW, 4, register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- gp_valid  in  NREQ  general requester i has a write pending
- gp_ready  out  NREQ  general requester i granted this cycle
- gp_reg  in  NREQ*AW  destination index, requester i at bits [i*AW +: AW]
- gp_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- md_valid  in  1  mul/div result pending
- md_ready  out  1  mul/div granted this cycle
- md_reg  in  AW  destination index for the low word
- md_lo  in  DW  low word, or quotient
- md_hi  in  DW  high word, or remainder, destined for R0
- hold  in  1  when 1, no grants are issued (pipeline freeze)
- write_reg  out  AW  to register file write_reg
- write_data  out  DW  to register file write_data
- r0  out  DW  to register file r0
- reg_write  out  2  [1] general port enable, [0] R0 port enable
- grant_id  out  2  slot of the last issued grant: 0..NREQ-1 general, NREQ mul/div

Behaviour:
- Slots: general requesters 0..NREQ-1, mul/div is slot NREQ. Round-robin runs over NREQ+1 slots.
- Reset (reset==0 at a clk edge):
  - rr_ptr=0, reg_write=2'b00, write_reg=0, write_data=0, r0=0, grant_id=0.
  - gp_ready and md_ready are forced to 0 while reset is low.
- Grant logic (combinational from current inputs and rr_ptr):
  - Search slots starting at rr_ptr, wrapping modulo NREQ+1.
  - The first slot with valid=1 gets its ready=1. All other readies are 0.
  - No grant when hold=1 or no slot is valid.
  - Exactly one ready is high, or none.
- Transfer happens on valid&&ready at the clk edge.
  - Requesters must hold valid, reg and data stable until ready.
  - Deasserting valid before ready is allowed; the request is simply withdrawn.
- Pointer update: after a grant to slot g, rr_ptr <= (g==NREQ) ? 0 : g+1. With no grant, rr_ptr holds.
- Output update at the edge after transfer (latency 1 cycle, request to register-file write strobe):
  - General grant g: reg_write<=2'b10, write_reg<=gp_reg[g], write_data<=gp_data[g]. r0 holds.
  - Mul/div grant, md_reg!=0: reg_write<=2'b11, write_reg<=md_reg, write_data<=md_lo, r0<=md_hi.
  - Mul/div grant, md_reg==0: reg_write<=2'b01, r0<=md_hi. md_lo is dropped; hi wins, matching register file port precedence. write_reg and write_data hold.
  - grant_id<=g on every grant.
- No grant in a cycle (idle, hold, or reset released with nothing valid): reg_write<=2'b00. write_reg, write_data, r0 and grant_id hold their values.
- General write with gp_reg==0 is legal: reg_write=2'b10, write_reg=0.
- Throughput: one grant per cycle maximum. Back-to-back grants to the same slot are allowed only if it is the sole valid slot.
- Fairness: a continuously valid slot is granted within NREQ+1 cycles while hold=0.
- hold asserted mid-stream:
  - Grants stop immediately (same cycle).
  - The output register already loaded still writes on its cycle. The following cycle has reg_write=00.
- Reset mid-operation overrides everything: pending requests are not granted, and outputs go to reset values on that edge.

Test Plan:
- Reset release, single write: reset=0 for 2 cycles, then gp_valid[1]=1, gp_reg[1]=4'h5, gp_data[1]=16'h1234 → gp_ready[1]=1 that cycle; next cycle reg_write=2'b10, write_reg=5, write_data=16'h1234, grant_id=1; then reg_write=00.
- Round-robin fairness: all gp_valid=3'b111 and md_valid=1 held for 8 cycles, rr_ptr=0 → grant order 0,1,2,3(md),0,1,2,3; each reg_write pulse carries that requester's data.
- Mul/div dual write: md_valid=1, md_reg=4'h3, md_lo=16'h00FF, md_hi=16'hFF00 → next cycle reg_write=2'b11, write_reg=3, write_data=16'h00FF, r0=16'hFF00.
- Mul/div to R0: md_reg=0, md_lo=16'hAAAA, md_hi=16'h5555 → reg_write=2'b01, r0=16'h5555, write_reg/write_data unchanged.
- Hold: gp_valid[0]=1 with hold=1 for 3 cycles → gp_ready=0, reg_write=00 throughout; hold=0 → grant that cycle, write one cycle later.
- Reset mid-stream: grant issued, reset=0 at the next edge → reg_write=00, r0=0, rr_ptr=0; after release with gp_valid[2]=1 only, slot 2 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16x16 register file.
// Round-robin over NREQ single-write requesters plus one mul/div requester
// (slot NREQ) that writes Rd and R0 in the same cycle. Write outputs are
// registered and drive the register file write inputs directly.
module regfile_wb_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 16,
   parameter int unsigned AW   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    gp_valid,
   output logic [NREQ-1:0]    gp_ready,
   input  logic [NREQ*AW-1:0] gp_reg,
   input  logic [NREQ*DW-1:0] gp_data,
   input  logic               md_valid,
   output logic               md_ready,
   input  logic [AW-1:0]      md_reg,
   input  logic [DW-1:0]      md_lo,
   input  logic [DW-1:0]      md_hi,
   input  logic               hold,
   output logic [AW-1:0]      write_reg,
   output logic [DW-1:0]      write_data,
   output logic [DW-1:0]      r0,
   output logic [1:0]         reg_write,
   output logic [1:0]         grant_id
);

   localparam int unsigned NS = NREQ + 1;
   localparam int unsigned PW = $clog2(NS);

   logic [NS-1:0] slot_valid;
   logic          grant_vld;
   logic [PW-1:0] grant_slot;
   logic [NS-1:0] grant_vec;
   logic [PW-1:0] search_idx;

   logic [PW-1:0] rr_ptr_q,     rr_ptr_d;
   logic [AW-1:0] write_reg_q,  write_reg_d;
   logic [DW-1:0] write_data_q, write_data_d;
   logic [DW-1:0] r0_q,         r0_d;
   logic [1:0]    reg_write_q,  reg_write_d;
   logic [1:0]    grant_id_q,   grant_id_d;

   assign slot_valid = {md_valid, gp_valid};

   // Pick the first valid slot at or after rr_ptr; nothing during reset or hold.
   always_comb begin
      grant_vld  = 1'b0;
      grant_slot = '0;
      grant_vec  = '0;
      search_idx = '0;
      if (reset && !hold) begin
         for (int k = 0; k < int'(NS); k++) begin
            search_idx = PW'((int'(rr_ptr_q) + k) % int'(NS));
            if (!grant_vld && slot_valid[search_idx]) begin
               grant_vld  = 1'b1;
               grant_slot = search_idx;
            end
         end
      end
      if (grant_vld) begin
         grant_vec = NS'(1) << grant_slot;
      end
   end

   assign gp_ready = grant_vec[NREQ-1:0];
   assign md_ready = grant_vec[NREQ];

   // Next pointer and write-back register contents for the granted slot.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      r0_d         = r0_q;
      reg_write_d  = 2'b00;
      grant_id_d   = grant_id_q;
      if (grant_vld) begin
         grant_id_d = 2'(grant_slot);
         rr_ptr_d   = (grant_slot == PW'(NREQ)) ? '0 : grant_slot + PW'(1);
         if (grant_vec[NREQ]) begin
            // R0 port wins when both would target R0, so the low word is dropped.
            r0_d = md_hi;
            if (md_reg != '0) begin
               reg_write_d  = 2'b11;
               write_reg_d  = md_reg;
               write_data_d = md_lo;
            end else begin
               reg_write_d  = 2'b01;
            end
         end else begin
            reg_write_d = 2'b10;
            for (int i = 0; i < int'(NREQ); i++) begin
               if (grant_vec[i]) begin
                  write_reg_d  = gp_reg[i*AW +: AW];
                  write_data_d = gp_data[i*DW +: DW];
               end
            end
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q     <= '0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         r0_q         <= '0;
         reg_write_q  <= 2'b00;
         grant_id_q   <= 2'b00;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         r0_q         <= r0_d;
         reg_write_q  <= reg_write_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;
   assign r0         = r0_q;
   assign reg_write  = reg_write_q;
   assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected
// write-back records, a monitor pops one per nonzero reg_write strobe.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [1:0]  rw;
      logic [3:0]  wreg;
      logic [15:0] wdata;
      logic [15:0] r0;
      logic [1:0]  gid;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  gp_valid;
   logic [2:0]  gp_ready;
   logic [11:0] gp_reg;
   logic [47:0] gp_data;
   logic        md_valid;
   logic        md_ready;
   logic [3:0]  md_reg;
   logic [15:0] md_lo;
   logic [15:0] md_hi;
   logic        hold;
   logic [3:0]  write_reg;
   logic [15:0] write_data;
   logic [15:0] r0;
   logic [1:0]  reg_write;
   logic [1:0]  grant_id;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   logic [3:0]  rr_reg  [3] = '{4'h1, 4'h2, 4'h6};
   logic [15:0] rr_data [3] = '{16'hA000, 16'hA111, 16'hA222};

   regfile_wb_arbiter dut (
      .clk        (clk),
      .reset      (rst_n),
      .gp_valid   (gp_valid),
      .gp_ready   (gp_ready),
      .gp_reg     (gp_reg),
      .gp_data    (gp_data),
      .md_valid   (md_valid),
      .md_ready   (md_ready),
      .md_reg     (md_reg),
      .md_lo      (md_lo),
      .md_hi      (md_hi),
      .hold       (hold),
      .write_reg  (write_reg),
      .write_data (write_data),
      .r0         (r0),
      .reg_write  (reg_write),
      .grant_id   (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] rw, input logic [3:0] wr, input logic [15:0] wd,
                       input logic [15:0] rv, input logic [1:0] g);
      exp_t e;
      e.rw = rw; e.wreg = wr; e.wdata = wd; e.r0 = rv; e.gid = g;
      sb.push_back(e);
   endtask

   task automatic set_gp(input int i, input logic [3:0] r, input logic [15:0] d);
      gp_reg[i*4 +: 4]   = r;
      gp_data[i*16 +: 16] = d;
   endtask

   // Check readies mid-cycle, then advance past the next rising edge.
   task automatic grant_cycle(input logic [2:0] exp_gp, input logic exp_md, input string tag);
      @(negedge clk);
      chk({tag, "_gp_ready"}, 32'(gp_ready), 32'(exp_gp));
      chk({tag, "_md_ready"}, 32'(md_ready), 32'(exp_md));
      @(posedge clk);
      #1;
   endtask

   task automatic out_chk(input string tag, input logic [1:0] rw, input logic [3:0] wr,
                          input logic [15:0] wd, input logic [15:0] rv, input logic [1:0] g);
      chk({tag, "_reg_write"},  32'(reg_write),  32'(rw));
      chk({tag, "_write_reg"},  32'(write_reg),  32'(wr));
      chk({tag, "_write_data"}, 32'(write_data), 32'(wd));
      chk({tag, "_r0"},         32'(r0),         32'(rv));
      chk({tag, "_grant_id"},   32'(grant_id),   32'(g));
   endtask

   // Monitor: every write strobe must match the oldest expected record.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && reg_write !== 2'b00) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: got reg_write=%b write_reg=%0h expected no write",
                        reg_write, write_reg);
            end else begin
               e = sb.pop_front();
               out_chk("wb", e.rw, e.wreg, e.wdata, e.r0, e.gid);
            end
         end
      end
   end

   initial begin
      int         slot;
      logic [15:0] exp_r0;
      logic [2:0]  eg;

      rst_n = 1'b0; hold = 1'b0; gp_valid = '0; md_valid = 1'b0;
      gp_reg = '0; gp_data = '0; md_reg = '0; md_lo = '0; md_hi = '0;
      @(posedge clk); #1;

      // Requests during reset are never granted; outputs sit at reset values.
      gp_valid = 3'b111; md_valid = 1'b1;
      grant_cycle(3'b000, 1'b0, "in_rst");
      @(negedge clk);
      out_chk("rst", 2'b00, 4'h0, 16'h0, 16'h0, 2'd0);
      @(posedge clk); #1;
      mon_en = 1'b1;
      gp_valid = '0; md_valid = 1'b0;

      // Single general write from slot 1.
      rst_n = 1'b1;
      set_gp(1, 4'h5, 16'h1234);
      gp_valid = 3'b010;
      push(2'b10, 4'h5, 16'h1234, 16'h0, 2'd1);
      grant_cycle(3'b010, 1'b0, "single");
      gp_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      out_chk("idle", 2'b00, 4'h5, 16'h1234, 16'h0, 2'd1);
      @(posedge clk); #1;

      // Mul/div dual write (pointer sits at 2, so slot 3 is found next).
      md_reg = 4'h3; md_lo = 16'h00FF; md_hi = 16'hFF00; md_valid = 1'b1;
      push(2'b11, 4'h3, 16'h00FF, 16'hFF00, 2'd3);
      grant_cycle(3'b000, 1'b1, "md_dual");
      md_valid = 1'b0;

      // Round-robin over all four slots starting from pointer 0.
      for (int i = 0; i < 3; i++) set_gp(i, rr_reg[i], rr_data[i]);
      md_reg = 4'h7; md_lo = 16'hB0B0; md_hi = 16'hC0C0;
      gp_valid = 3'b111; md_valid = 1'b1;
      exp_r0 = 16'hFF00;
      for (int i = 0; i < 8; i++) begin
         slot = i % 4;
         if (slot == 3) begin
            exp_r0 = 16'hC0C0;
            push(2'b11, 4'h7, 16'hB0B0, exp_r0, 2'd3);
            eg = 3'b000;
         end else begin
            push(2'b10, rr_reg[slot], rr_data[slot], exp_r0, 2'(slot));
            eg = 3'(1 << slot);
         end
         grant_cycle(eg, slot == 3, "rr");
      end
      gp_valid = '0; md_valid = 1'b0;

      // Mul/div targeting R0: only the R0 port writes.
      md_reg = 4'h0; md_lo = 16'hAAAA; md_hi = 16'h5555; md_valid = 1'b1;
      push(2'b01, 4'h7, 16'hB0B0, 16'h5555, 2'd3);
      grant_cycle(3'b000, 1'b1, "md_r0");
      md_valid = 1'b0;

      // Hold blocks grants; release grants in the same cycle.
      hold = 1'b1; gp_valid = 3'b001;
      for (int i = 0; i < 3; i++) begin
         grant_cycle(3'b000, 1'b0, "hold");
         chk("hold_reg_write", 32'(reg_write), 32'(2'b00));
      end
      hold = 1'b0;
      push(2'b10, 4'h1, 16'hA000, 16'h5555, 2'd0);
      grant_cycle(3'b001, 1'b0, "hold_rel");

      // Reset mid-stream: pending requests ignored, pointer returns to 0.
      gp_valid = 3'b010;
      push(2'b10, 4'h2, 16'hA111, 16'h5555, 2'd1);
      grant_cycle(3'b010, 1'b0, "pre_rst");
      rst_n = 1'b0; gp_valid = 3'b111; md_valid = 1'b1;
      grant_cycle(3'b000, 1'b0, "mid_rst");
      out_chk("mid_rst", 2'b00, 4'h0, 16'h0, 16'h0, 2'd0);
      rst_n = 1'b1; md_valid = 1'b0;
      push(2'b10, 4'h1, 16'hA000, 16'h0, 2'd0);
      grant_cycle(3'b001, 1'b0, "rst_ptr");
      gp_valid = 3'b100;
      push(2'b10, 4'h6, 16'hA222, 16'h0, 2'd2);
      grant_cycle(3'b100, 1'b0, "rst_slot2");

      // General write to register 0 is an ordinary general-port write.
      set_gp(0, 4'h0, 16'h0F0F);
      gp_valid = 3'b001;
      push(2'b10, 4'h0, 16'h0F0F, 16'h0, 2'd0);
      grant_cycle(3'b001, 1'b0, "gp_r0");
      gp_valid = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("drain_reg_write", 32'(reg_write), 32'(2'b00));
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
